// File: rtl/loteria_pkg.sv
// Shared types and limits for the lottery bet input path and game FSM.
package loteria_pkg;

  localparam int unsigned MAX_DIGITS      = 5;
  localparam int unsigned MAX_DIGIT_VALUE = 9;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    COLLECT,
    READY,
    DONE
  } state_t;

endpackage

// File: rtl/filtro_botao.sv
// Button conditioner: 2-flop synchronizer, optional debounce, rising-edge press pulse.
// Debounce filter is built only when CAPTURA_APOSTA_DEBOUNCE_EN is defined.
module filtro_botao #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic       sync1_q;
  logic       sync2_q;
  logic       level;
  logic       prev_q;
  logic       armed_q;
  logic [1:0] fill_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

`ifdef CAPTURA_APOSTA_DEBOUNCE_EN
  logic [15:0] cnt_q;
  logic        deb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
      deb_q <= 1'b0;
    end else if (sync2_q == deb_q) begin
      cnt_q <= 16'd0;
    end else if (cnt_q >= DEBOUNCE_CYCLES - 16'd1) begin
      deb_q <= sync2_q;
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign level = deb_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign level      = sync2_q;
`endif

  // Arm only after a genuine low has passed through the synchronizer, so a key held
  // across reset release cannot fire until it is released and pressed again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q <= level;
      if (fill_q[1] && !sync2_q && !level) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign press = level & ~prev_q & armed_q;

endmodule

// File: rtl/captura_aposta.sv
// Bet input stage: conditioned insert/finish presses, digit capture and 5-digit sequence lock.
// Button debounce is enabled by defining CAPTURA_APOSTA_DEBOUNCE_EN.
module captura_aposta #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned MAX_DIGITS      = loteria_pkg::MAX_DIGITS,
  parameter int unsigned MAX_DIGIT_VALUE = loteria_pkg::MAX_DIGIT_VALUE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_insert,
  input  logic       key_finish,
  input  logic [3:0] sw_num,
  output logic [3:0] num,
  output logic       insert,
  output logic       finish,
  output logic       err,
  output logic [2:0] digit_cnt
);

  import loteria_pkg::*;

  localparam digit_t     MaxVal = digit_t'(MAX_DIGIT_VALUE);
  localparam logic [2:0] MaxCnt = 3'(MAX_DIGITS);

  logic   ins_press;
  logic   fin_press;
  digit_t sw_s1_q, sw_s2_q;
  state_t state_q, state_d;
  digit_t num_q, num_d;
  logic [2:0] cnt_q, cnt_d;
  logic   insert_q, insert_d;
  logic   finish_q, finish_d;
  logic   err_q, err_d;

  filtro_botao #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_filtro_insert (
    .clk   (clk),
    .reset (reset),
    .key   (key_insert),
    .press (ins_press)
  );

  filtro_botao #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_filtro_finish (
    .clk   (clk),
    .reset (reset),
    .key   (key_finish),
    .press (fin_press)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      state_q  <= COLLECT;
      num_q    <= '0;
      cnt_q    <= 3'd0;
      insert_q <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sw_s1_q  <= sw_num;
      sw_s2_q  <= sw_s1_q;
      state_q  <= state_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      insert_q <= insert_d;
      finish_q <= finish_d;
      err_q    <= err_d;
    end
  end

  // Each press is judged against the current state only, so a simultaneous pair
  // yields at most one action.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    insert_d = 1'b0;
    finish_d = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (ins_press) begin
          if (sw_s2_q <= MaxVal) begin
            num_d    = sw_s2_q;
            insert_d = 1'b1;
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q + 3'd1 == MaxCnt) begin
              state_d = READY;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      READY: begin
        if (fin_press) begin
          finish_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
      end
      default: state_d = COLLECT;
    endcase
  end

  assign num       = num_q;
  assign insert    = insert_q;
  assign finish    = finish_q;
  assign err       = err_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_captura_aposta.sv
// Directed self-checking bench for captura_aposta (debounce length 4 when enabled).
module tb_captura_aposta;

  localparam int DB = 4;
`ifdef CAPTURA_APOSTA_DEBOUNCE_EN
  localparam int LAT = DB + 3;
  localparam int NB  = 1;
`else
  localparam int LAT = 3;
  localparam int NB  = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_insert = 1'b0;
  logic       key_finish = 1'b0;
  logic [3:0] sw_num = 4'd0;
  logic [3:0] num;
  logic       insert;
  logic       finish;
  logic       err;
  logic [2:0] digit_cnt;

  int checks = 0;
  int failures = 0;
  int ins_n = 0;
  int fin_n = 0;
  int err_n = 0;

  captura_aposta #(
    .DEBOUNCE_CYCLES (16'(DB)),
    .MAX_DIGITS      (5),
    .MAX_DIGIT_VALUE (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_insert (key_insert),
    .key_finish (key_finish),
    .sw_num     (sw_num),
    .num        (num),
    .insert     (insert),
    .finish     (finish),
    .err        (err),
    .digit_cnt  (digit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (insert) ins_n++;
    if (finish) fin_n++;
    if (err) err_n++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    key_insert = 1'b0;
    key_finish = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic press(input logic ins, input logic fin, input logic [3:0] d);
    sw_num = d;
    repeat (4) @(negedge clk);
    key_insert = ins;
    key_finish = fin;
    repeat (LAT + 3) @(negedge clk);
    key_insert = 1'b0;
    key_finish = 1'b0;
    repeat (DB + 8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (num !== 4'd0) begin failures++; $display("FAIL reset_num got=%0d want=0", num); end
    checks++; if (insert !== 1'b0) begin failures++; $display("FAIL reset_insert got=%b want=0", insert); end
    checks++; if (finish !== 1'b0) begin failures++; $display("FAIL reset_finish got=%b want=0", finish); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (digit_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", digit_cnt); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_five_digits();
    logic [3:0] digits [5];
    int hit, width, b;
    logic [3:0] num_at;
    digits[0] = 4'd5; digits[1] = 4'd0; digits[2] = 4'd9; digits[3] = 4'd6; digits[4] = 4'd7;
    sw_num = digits[0];
    repeat (4) @(negedge clk);
    key_insert = 1'b1;
    hit = 0; width = 0; num_at = 4'd0;
    for (int i = 1; i <= LAT + 3; i++) begin
      @(negedge clk);
      if (insert === 1'b1) begin
        if (hit == 0) begin hit = i; num_at = num; end
        width++;
      end
    end
    key_insert = 1'b0;
    repeat (DB + 8) @(negedge clk);
    checks++; if (hit != LAT) begin failures++; $display("FAIL first_latency got=%0d want=%0d", hit, LAT); end
    checks++; if (width != 1) begin failures++; $display("FAIL first_width got=%0d want=1", width); end
    checks++; if (num_at !== 4'd5) begin failures++; $display("FAIL first_num got=%0d want=5", num_at); end
    checks++; if (digit_cnt !== 3'd1) begin failures++; $display("FAIL first_cnt got=%0d want=1", digit_cnt); end
    for (int k = 1; k < 5; k++) begin
      b = ins_n;
      press(1'b1, 1'b0, digits[k]);
      checks++; if (ins_n - b != 1) begin failures++; $display("FAIL digit%0d_pulses got=%0d want=1", k, ins_n - b); end
      checks++; if (num !== digits[k]) begin failures++; $display("FAIL digit%0d_num got=%0d want=%0d", k, num, digits[k]); end
      checks++; if (digit_cnt !== 3'(k + 1)) begin failures++; $display("FAIL digit%0d_cnt got=%0d want=%0d", k, digit_cnt, k + 1); end
    end
  endtask

  task automatic test_ready_done();
    int bi, bf, be;
    bi = ins_n; be = err_n;
    press(1'b1, 1'b0, 4'd4);
    checks++; if (ins_n - bi != 0) begin failures++; $display("FAIL ready_insert got=%0d want=0", ins_n - bi); end
    checks++; if (err_n - be != 0) begin failures++; $display("FAIL ready_err got=%0d want=0", err_n - be); end
    checks++; if (digit_cnt !== 3'd5) begin failures++; $display("FAIL ready_cnt got=%0d want=5", digit_cnt); end
    bf = fin_n;
    press(1'b0, 1'b1, 4'd0);
    checks++; if (fin_n - bf != 1) begin failures++; $display("FAIL ready_finish got=%0d want=1", fin_n - bf); end
    bi = ins_n; bf = fin_n;
    press(1'b1, 1'b0, 4'd2);
    press(1'b0, 1'b1, 4'd2);
    checks++; if (ins_n - bi != 0) begin failures++; $display("FAIL done_insert got=%0d want=0", ins_n - bi); end
    checks++; if (fin_n - bf != 0) begin failures++; $display("FAIL done_finish got=%0d want=0", fin_n - bf); end
    checks++; if (num !== 4'd7) begin failures++; $display("FAIL done_num got=%0d want=7", num); end
  endtask

  task automatic test_err();
    int bi, be;
    do_reset();
    bi = ins_n; be = err_n;
    press(1'b1, 1'b0, 4'd12);
    checks++; if (err_n - be != 1) begin failures++; $display("FAIL err_pulse got=%0d want=1", err_n - be); end
    checks++; if (ins_n - bi != 0) begin failures++; $display("FAIL err_insert got=%0d want=0", ins_n - bi); end
    checks++; if (digit_cnt !== 3'd0) begin failures++; $display("FAIL err_cnt got=%0d want=0", digit_cnt); end
    checks++; if (num !== 4'd0) begin failures++; $display("FAIL err_num got=%0d want=0", num); end
    bi = ins_n;
    press(1'b1, 1'b0, 4'd3);
    checks++; if (ins_n - bi != 1) begin failures++; $display("FAIL after_err_insert got=%0d want=1", ins_n - bi); end
    checks++; if (num !== 4'd3) begin failures++; $display("FAIL after_err_num got=%0d want=3", num); end
    checks++; if (digit_cnt !== 3'd1) begin failures++; $display("FAIL after_err_cnt got=%0d want=1", digit_cnt); end
  endtask

  task automatic test_finish_collect();
    int bi, bf;
    press(1'b1, 1'b0, 4'd8);
    bf = fin_n;
    press(1'b0, 1'b1, 4'd8);
    checks++; if (fin_n - bf != 0) begin failures++; $display("FAIL collect_finish got=%0d want=0", fin_n - bf); end
    checks++; if (digit_cnt !== 3'd2) begin failures++; $display("FAIL collect_cnt got=%0d want=2", digit_cnt); end
    press(1'b1, 1'b0, 4'd1);
    press(1'b1, 1'b0, 4'd2);
    bi = ins_n; bf = fin_n;
    press(1'b1, 1'b1, 4'd6);
    checks++; if (ins_n - bi != 1) begin failures++; $display("FAIL both_insert got=%0d want=1", ins_n - bi); end
    checks++; if (fin_n - bf != 0) begin failures++; $display("FAIL both_finish got=%0d want=0", fin_n - bf); end
    checks++; if (digit_cnt !== 3'd5) begin failures++; $display("FAIL both_cnt got=%0d want=5", digit_cnt); end
    checks++; if (num !== 4'd6) begin failures++; $display("FAIL both_num got=%0d want=6", num); end
    bf = fin_n;
    press(1'b0, 1'b1, 4'd0);
    checks++; if (fin_n - bf != 1) begin failures++; $display("FAIL both_then_finish got=%0d want=1", fin_n - bf); end
  endtask

  task automatic test_bounce();
    int bi, hit;
    do_reset();
    bi = ins_n;
    sw_num = 4'd1;
    repeat (4) @(negedge clk);
    key_insert = 1'b1;
    repeat (2) @(negedge clk);
    key_insert = 1'b0;
    repeat (2) @(negedge clk);
    key_insert = 1'b1;
    hit = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      @(negedge clk);
      if (insert === 1'b1 && hit == 0) hit = i;
    end
    key_insert = 1'b0;
    repeat (DB + 8) @(negedge clk);
    checks++; if (hit != LAT) begin failures++; $display("FAIL bounce_latency got=%0d want=%0d", hit, LAT); end
    checks++; if (ins_n - bi != NB) begin failures++; $display("FAIL bounce_pulses got=%0d want=%0d", ins_n - bi, NB); end
    checks++; if (digit_cnt !== 3'(NB)) begin failures++; $display("FAIL bounce_cnt got=%0d want=%0d", digit_cnt, NB); end
  endtask

  task automatic test_reset_mid();
    int bi;
    do_reset();
    press(1'b1, 1'b0, 4'd4);
    press(1'b1, 1'b0, 4'd5);
    press(1'b1, 1'b0, 4'd6);
    checks++; if (digit_cnt !== 3'd3) begin failures++; $display("FAIL mid_pre_cnt got=%0d want=3", digit_cnt); end
    key_insert = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (num !== 4'd0) begin failures++; $display("FAIL mid_num got=%0d want=0", num); end
    checks++; if ({insert, finish, err} !== 3'b000) begin failures++; $display("FAIL mid_pulses got=%b want=000", {insert, finish, err}); end
    checks++; if (digit_cnt !== 3'd0) begin failures++; $display("FAIL mid_cnt got=%0d want=0", digit_cnt); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bi = ins_n;
    repeat (LAT + 10) @(negedge clk);
    checks++; if (ins_n - bi != 0) begin failures++; $display("FAIL held_through_reset got=%0d want=0", ins_n - bi); end
    key_insert = 1'b0;
    repeat (DB + 8) @(negedge clk);
    bi = ins_n;
    press(1'b1, 1'b0, 4'd2);
    checks++; if (ins_n - bi != 1) begin failures++; $display("FAIL repress_insert got=%0d want=1", ins_n - bi); end
    checks++; if (num !== 4'd2) begin failures++; $display("FAIL repress_num got=%0d want=2", num); end
    checks++; if (digit_cnt !== 3'd1) begin failures++; $display("FAIL repress_cnt got=%0d want=1", digit_cnt); end
  endtask

  initial begin
    test_reset();
    test_five_digits();
    test_ready_done();
    test_err();
    test_finish_collect();
    test_bounce();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
